// File: rtl/wra_layer_sequencer.sv
// wra_layer_sequencer: descriptor-table driven per-layer filter-transform load and layer start for WRA_ctl.
// Optional build macro WRA_SEQ_WATCHDOG_EN adds a RUN-phase watchdog and the wdog_err output.
module wra_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int DESC_W     = 64,
    parameter int GT_DW      = 512,
    localparam int LW        = $clog2(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [LW-1:0]     cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    input  logic [LW:0]       num_layers,
    input  logic              start,
    input  logic              gt_src_valid,
    input  logic [GT_DW-1:0]  gt_src_data,
    output logic              gt_src_ready,
    output logic              we_Gt,
    output logic [15:0]       a_Gt,
    output logic [GT_DW-1:0]  d_Gt,
    output logic              inputbstart_op,
    input  logic              Layer_Finish,
    output logic [4:0]        numswitchH_op,
    output logic [8:0]        numslideH_op,
    output logic [4:0]        numslideV_op,
    output logic [4:0]        NInch_D_PInch_op,
    output logic [4:0]        NOuch_D_POuch_op,
    output logic [7:0]        cellnum_op,
    output logic [7:0]        linenum_op,
    output logic [1:0]        fixpoint_op,
    output logic              stride_op,
    output logic              kernelsize_op,
    output logic              padding_op,
    output logic              poolingen_op,
    output logic              relu_op,
`ifdef WRA_SEQ_WATCHDOG_EN
    output logic              wdog_err,
`endif
    output logic              busy,
    output logic              done,
    output logic [LW-1:0]     cur_layer
);

    typedef enum logic [2:0] {IDLE, LOAD_DESC, LOAD_GT, KICK, RUN, NEXT, FIN} state_t;

    state_t            state;
    logic [DESC_W-1:0] table_q [MAX_LAYERS];
    logic [DESC_W-1:0] desc;
    logic [LW:0]       num_q;
    logic [11:0]       gt_last_q;
    logic [11:0]       cnt;
    logic              last_layer;
`ifdef WRA_SEQ_WATCHDOG_EN
    logic [19:0]       wdog;
`endif

    assign desc       = table_q[cur_layer];
    assign last_layer = {1'b0, cur_layer} == num_q - (LW+1)'(1);

    // Descriptor table is writable only while the sequencer is idle; contents survive no reset.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE)
            table_q[cfg_addr] <= cfg_wdata;
    end

    // Layer sequencing FSM with registered strobes, filter beat forwarding and layer configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            num_q            <= '0;
            gt_last_q        <= '0;
            cnt              <= '0;
            gt_src_ready     <= 1'b0;
            we_Gt            <= 1'b0;
            a_Gt             <= '0;
            d_Gt             <= '0;
            inputbstart_op   <= 1'b0;
            numswitchH_op    <= '0;
            numslideH_op     <= '0;
            numslideV_op     <= '0;
            NInch_D_PInch_op <= '0;
            NOuch_D_POuch_op <= '0;
            cellnum_op       <= '0;
            linenum_op       <= '0;
            fixpoint_op      <= '0;
            stride_op        <= 1'b0;
            kernelsize_op    <= 1'b0;
            padding_op       <= 1'b0;
            poolingen_op     <= 1'b0;
            relu_op          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cur_layer        <= '0;
`ifdef WRA_SEQ_WATCHDOG_EN
            wdog             <= '0;
            wdog_err         <= 1'b0;
`endif
        end else begin
            we_Gt          <= 1'b0;
            inputbstart_op <= 1'b0;
            done           <= 1'b0;
`ifdef WRA_SEQ_WATCHDOG_EN
            wdog_err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && num_layers != '0) begin
                        state     <= LOAD_DESC;
                        busy      <= 1'b1;
                        cur_layer <= '0;
                        num_q     <= num_layers;
                    end else if (start) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                LOAD_DESC: begin
                    gt_last_q        <= desc[63:52];
                    numswitchH_op    <= desc[51:47];
                    numslideH_op     <= desc[46:38];
                    numslideV_op     <= desc[37:33];
                    NInch_D_PInch_op <= desc[32:28];
                    NOuch_D_POuch_op <= desc[27:23];
                    cellnum_op       <= desc[22:15];
                    linenum_op       <= desc[14:7];
                    fixpoint_op      <= desc[6:5];
                    stride_op        <= desc[4];
                    kernelsize_op    <= desc[3];
                    padding_op       <= desc[2];
                    poolingen_op     <= desc[1];
                    relu_op          <= desc[0];
                    cnt              <= '0;
                    gt_src_ready     <= 1'b1;
                    state            <= LOAD_GT;
                end
                LOAD_GT: begin
                    if (gt_src_valid && gt_src_ready) begin
                        we_Gt <= 1'b1;
                        a_Gt  <= {4'b0, cnt};
                        d_Gt  <= gt_src_data;
                        cnt   <= cnt + 12'd1;
                        if (cnt == gt_last_q) begin
                            gt_src_ready <= 1'b0;
                            state        <= KICK;
                        end
                    end
                end
                KICK: begin
                    inputbstart_op <= 1'b1;
                    state          <= RUN;
`ifdef WRA_SEQ_WATCHDOG_EN
                    wdog           <= '0;
`endif
                end
                RUN: begin
                    if (Layer_Finish)
                        state <= NEXT;
`ifdef WRA_SEQ_WATCHDOG_EN
                    else if (&wdog) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        wdog_err <= 1'b1;
                    end else
                        wdog <= wdog + 20'd1;
`endif
                end
                NEXT: begin
                    if (last_layer) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cur_layer <= cur_layer + LW'(1);
                        state     <= LOAD_DESC;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wra_layer_sequencer.sv
// tb_wra_layer_sequencer: directed self-checking bench for wra_layer_sequencer.
module tb_wra_layer_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_we = 1'b0;
    logic [2:0]   cfg_addr = '0;
    logic [63:0]  cfg_wdata = '0;
    logic [3:0]   num_layers = '0;
    logic         start = 1'b0;
    logic         gt_src_valid = 1'b0;
    logic [511:0] gt_src_data = '0;
    logic         Layer_Finish = 1'b0;
    logic         gt_src_ready, we_Gt, inputbstart_op, busy, done;
    logic [15:0]  a_Gt;
    logic [511:0] d_Gt;
    logic [4:0]   numswitchH_op, numslideV_op, NInch_D_PInch_op, NOuch_D_POuch_op;
    logic [8:0]   numslideH_op;
    logic [7:0]   cellnum_op, linenum_op;
    logic [1:0]   fixpoint_op;
    logic         stride_op, kernelsize_op, padding_op, poolingen_op, relu_op;
    logic [2:0]   cur_layer;
`ifdef WRA_SEQ_WATCHDOG_EN
    logic         wdog_err;
`endif
    int tests = 0;
    int fails = 0;

    wra_layer_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_layers(num_layers), .start(start), .gt_src_valid(gt_src_valid),
        .gt_src_data(gt_src_data), .gt_src_ready(gt_src_ready), .we_Gt(we_Gt), .a_Gt(a_Gt),
        .d_Gt(d_Gt), .inputbstart_op(inputbstart_op), .Layer_Finish(Layer_Finish),
        .numswitchH_op(numswitchH_op), .numslideH_op(numslideH_op), .numslideV_op(numslideV_op),
        .NInch_D_PInch_op(NInch_D_PInch_op), .NOuch_D_POuch_op(NOuch_D_POuch_op),
        .cellnum_op(cellnum_op), .linenum_op(linenum_op), .fixpoint_op(fixpoint_op),
        .stride_op(stride_op), .kernelsize_op(kernelsize_op), .padding_op(padding_op),
        .poolingen_op(poolingen_op), .relu_op(relu_op),
`ifdef WRA_SEQ_WATCHDOG_EN
        .wdog_err(wdog_err),
`endif
        .busy(busy), .done(done), .cur_layer(cur_layer)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk_desc(input logic [11:0] gl, input int tag);
        return {gl, 5'(tag), 9'(tag * 3), 5'(tag + 1), 5'(tag + 2), 5'(tag + 3),
                8'(tag + 4), 8'(tag + 5), 2'(tag), 5'(tag)};
    endfunction

    function automatic logic [511:0] mk_data(input int l, input int i);
        return {16{32'(l * 4096 + i) ^ 32'hA5A5_0000}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_desc(input int addr, input logic [63:0] d);
        cfg_we = 1'b1;
        cfg_addr = 3'(addr);
        cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Entered just after the edge that raised gt_src_ready; leaves just after Layer_Finish is taken.
    task automatic do_layer(input int layer, input int gl, input int tag, input bit gaps, input bit spur);
        logic [63:0] d;
        logic [51:0] ops;
        int idx, cyc;
        bit v;
        d = mk_desc(12'(gl), tag);
        ops = {numswitchH_op, numslideH_op, numslideV_op, NInch_D_PInch_op, NOuch_D_POuch_op,
               cellnum_op, linenum_op, fixpoint_op, stride_op, kernelsize_op, padding_op,
               poolingen_op, relu_op};
        tests++;
        if (ops !== d[51:0]) begin
            fails++;
            $display("FAIL ops layer %0d: got %h want %h", layer, ops, d[51:0]);
        end
        tests++;
        if (cur_layer !== 3'(layer)) begin
            fails++;
            $display("FAIL cur_layer: got %0d want %0d", cur_layer, layer);
        end
        idx = 0;
        cyc = 0;
        while (idx <= gl) begin
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            tests++;
            if (gt_src_ready !== 1'b1) begin
                fails++;
                $display("FAIL ready layer %0d beat %0d: got %b want 1", layer, idx, gt_src_ready);
            end
            gt_src_valid = v;
            gt_src_data = mk_data(layer, idx);
            Layer_Finish = spur && cyc == 3;
            step();
            tests++;
            if (v && (we_Gt !== 1'b1 || a_Gt !== 16'(idx) || d_Gt !== mk_data(layer, idx))) begin
                fails++;
                $display("FAIL beat layer %0d: we=%b a=%0d d=%h want we=1 a=%0d", layer, we_Gt, a_Gt, d_Gt[31:0], idx);
            end else if (!v && we_Gt !== 1'b0) begin
                fails++;
                $display("FAIL gap layer %0d: we=%b want 0", layer, we_Gt);
            end
            if (v)
                idx++;
            cyc++;
        end
        gt_src_valid = 1'b0;
        Layer_Finish = 1'b0;
        tests++;
        if (gt_src_ready !== 1'b0 || inputbstart_op !== 1'b0) begin
            fails++;
            $display("FAIL kick_pre layer %0d: ready=%b ibs=%b want 0 0", layer, gt_src_ready, inputbstart_op);
        end
        step();
        tests++;
        if (inputbstart_op !== 1'b1 || we_Gt !== 1'b0) begin
            fails++;
            $display("FAIL kick layer %0d: ibs=%b we=%b want 1 0", layer, inputbstart_op, we_Gt);
        end
        for (int k = 0; k < 3; k++) begin
            if (spur && k == 0) begin
                start = 1'b1;
                cfg_we = 1'b1;
                cfg_addr = 3'd1;
                cfg_wdata = '1;
            end
            step();
            start = 1'b0;
            cfg_we = 1'b0;
            tests++;
            if (inputbstart_op !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || gt_src_ready !== 1'b0) begin
                fails++;
                $display("FAIL run_wait layer %0d: ibs=%b busy=%b done=%b ready=%b want 0 1 0 0",
                         layer, inputbstart_op, busy, done, gt_src_ready);
            end
        end
        Layer_Finish = 1'b1;
        step();
        Layer_Finish = 1'b0;
    endtask

    task automatic run_net(input int nl, input int gl0, input int gl1, input int gl2,
                           input int tbase, input bit gaps, input int spur);
        int gls[3];
        gls = '{gl0, gl1, gl2};
        for (int l = 0; l < nl; l++)
            write_desc(l, mk_desc(12'(gls[l]), tbase + 10 * l));
        num_layers = 4'(nl);
        start = 1'b1;
        step();
        start = 1'b0;
        num_layers = 4'd1;
        tests++;
        if (busy !== 1'b1 || gt_src_ready !== 1'b0 || cur_layer !== 3'd0) begin
            fails++;
            $display("FAIL start: busy=%b ready=%b cur=%0d want 1 0 0", busy, gt_src_ready, cur_layer);
        end
        step();
        tests++;
        if (gt_src_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: ready=%b want 1", gt_src_ready);
        end
        for (int l = 0; l < nl; l++) begin
            do_layer(l, gls[l], tbase + 10 * l, gaps, spur == l);
            if (l < nl - 1) begin
                step();
                tests++;
                if (gt_src_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL next: ready=%b done=%b busy=%b want 0 0 1", gt_src_ready, done, busy);
                end
                step();
                tests++;
                if (gt_src_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL finish_latency: ready=%b want 1", gt_src_ready);
                end
            end else begin
                step();
                tests++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL done: done=%b busy=%b want 1 0", done, busy);
                end
                step();
                tests++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL done_pulse: done=%b want 0", done);
                end
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        tests++;
        if ({gt_src_ready, we_Gt, a_Gt, inputbstart_op, busy, done, cur_layer, numslideH_op, relu_op} !== '0 || d_Gt !== '0) begin
            fails++;
            $display("FAIL reset: outputs not all 0 (ready=%b we=%b busy=%b done=%b)", gt_src_ready, we_Gt, busy, done);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_three_layers();
        run_net(3, 195, 31, 159, 5, 1'b0, -1);
    endtask

    task automatic test_valid_gaps();
        run_net(1, 31, 0, 0, 9, 1'b1, -1);
    endtask

    task automatic test_spurious_finish();
        Layer_Finish = 1'b1;
        step();
        Layer_Finish = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || gt_src_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_finish: busy=%b ready=%b done=%b want 0 0 0", busy, gt_src_ready, done);
        end
        run_net(2, 7, 3, 0, 40, 1'b0, 0);
    endtask

    task automatic test_zero_layers();
        num_layers = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || we_Gt !== 1'b0 || inputbstart_op !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b we=%b ibs=%b want 1 0 0 0", done, busy, we_Gt, inputbstart_op);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if (done !== 1'b0 || we_Gt !== 1'b0 || inputbstart_op !== 1'b0 || gt_src_ready !== 1'b0) begin
                fails++;
                $display("FAIL zero_idle: done=%b we=%b ibs=%b ready=%b want 0 0 0 0", done, we_Gt, inputbstart_op, gt_src_ready);
            end
        end
    endtask

    task automatic test_mid_reset();
        write_desc(0, mk_desc(12'd5, 60));
        write_desc(1, mk_desc(12'd9, 70));
        num_layers = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        do_layer(0, 5, 60, 1'b0, 1'b0);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            gt_src_valid = 1'b1;
            gt_src_data = mk_data(1, k);
            step();
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({gt_src_ready, we_Gt, a_Gt, inputbstart_op, busy, done, cur_layer, numswitchH_op, cellnum_op} !== '0 || d_Gt !== '0) begin
            fails++;
            $display("FAIL mid_reset: ready=%b we=%b a=%0d busy=%b cur=%0d want all 0", gt_src_ready, we_Gt, a_Gt, busy, cur_layer);
        end
        gt_src_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_net(2, 5, 9, 0, 80, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_three_layers();
        test_valid_gaps();
        test_spurious_finish();
        test_zero_layers();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
